game_tick_scheduler: RTL

- Controller for the game-speed timebase.
- One shared divide counter produces a single-cycle `tick` enable and a 50%-duty `phase_out` square wave at one of three speed levels (slow/medium/fast).
- Sequences run/pause/stop and accepts speed changes from game logic via valid/ready.
- Optionally ramps difficulty automatically.
- Sits between the board clock and the game FSMs; those FSMs consume `tick` as a clock enable on `clk`.

---
 rtl/game_tick_scheduler.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler
//   Game-speed timebase. One shared divide counter produces a single-cycle
//   tick enable and a 50%-duty phase_out square wave at one of three speed
//   levels. Run/pause/stop sequencing, a valid/ready level-change port that
//   only switches speed on a period boundary while running, and an optional
//   automatic difficulty ramp.
//
//   Optional feature macro: GAME_TICK_STEP_EN
//     When defined, adds input `step`: a rising edge while paused emits one
//     tick (counted and ramped like a normal wrap) and restarts the period.
//
//   Timing: tick is registered from the wrap edge, so it is high during the
//   cycle after cnt reaches DIV-1; a consumer using it as a clock enable
//   sees the first tick on the DIV+1-th edge after the start edge.
module game_tick_scheduler #(
  parameter int unsigned DIV_SLOW   = 10000000,
  parameter int unsigned DIV_MED    = 2500000,
  parameter int unsigned DIV_FAST   = 1000000,
  parameter int unsigned CNT_W      = 30,
  parameter int unsigned RAMP_TICKS = 64,
  parameter int unsigned RAMP_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        stop,
  input  logic        ramp_en,
  input  logic        lvl_req_valid,
  input  logic [1:0]  lvl_req,
`ifdef GAME_TICK_STEP_EN
  input  logic        step,
`endif
  output logic        lvl_req_ready,
  output logic        tick,
  output logic        phase_out,
  output logic [1:0]  level,
  output logic        running,
  output logic [15:0] tick_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  L_DIV_SLOW  = CNT_W'(DIV_SLOW);
  localparam logic [CNT_W-1:0]  L_DIV_MED   = CNT_W'(DIV_MED);
  localparam logic [CNT_W-1:0]  L_DIV_FAST  = CNT_W'(DIV_FAST);
  localparam logic [RAMP_W-1:0] L_RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_level;
  logic              r_pending;
  logic [1:0]        r_pend_lvl;
  logic [RAMP_W-1:0] r_ramp_cnt;
  logic              r_tick;
  logic              r_phase;
  logic              r_running;
  logic              r_ready;
  logic [15:0]       r_tick_count;

  logic [CNT_W-1:0]  w_div;
  logic [CNT_W-1:0]  w_div_last;
  logic              w_phase_hi;
  logic              w_wrap;
  logic              w_step_evt;
  logic              w_event;
  logic              w_apply;
  logic              w_xfer;
  logic [1:0]        w_req_lvl;
  logic              w_ramp_last;

`ifdef GAME_TICK_STEP_EN
  logic              r_step_d;
`endif

  // Period selection and the per-cycle events derived from the current state.
  always_comb begin
    w_div = L_DIV_FAST;
    case (r_level)
      2'd0:    w_div = L_DIV_SLOW;
      2'd1:    w_div = L_DIV_MED;
      default: w_div = L_DIV_FAST;
    endcase
    w_div_last  = w_div - CNT_W'(1);
    w_phase_hi  = (r_cnt < (w_div >> 1));
    // A stop in the wrap cycle wins: the period is abandoned without a tick.
    w_wrap      = (r_state == S_RUN) && !stop && (r_cnt == w_div_last);
`ifdef GAME_TICK_STEP_EN
    w_step_evt  = (r_state == S_PAUSE) && !stop && step && !r_step_d;
`else
    w_step_evt  = 1'b0;
`endif
    w_event     = w_wrap || w_step_evt;
    // Outside RUN a pending level lands at once; in RUN only on a period boundary.
    w_apply     = r_pending && ((r_state != S_RUN) || w_event);
    w_xfer      = lvl_req_valid && r_ready;
    w_req_lvl   = (lvl_req == 2'd3) ? 2'd2 : lvl_req;
    w_ramp_last = (r_ramp_cnt == L_RAMP_LAST);
  end

  // Run/pause/stop FSM, divide counter, level handshake and ramp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_level      <= 2'd0;
      r_pending    <= 1'b0;
      r_pend_lvl   <= 2'd0;
      r_ramp_cnt   <= '0;
      r_tick       <= 1'b0;
      r_phase      <= 1'b0;
      r_running    <= 1'b0;
      r_ready      <= 1'b1;
      r_tick_count <= 16'd0;
`ifdef GAME_TICK_STEP_EN
      r_step_d     <= 1'b0;
`endif
    end else begin
`ifdef GAME_TICK_STEP_EN
      r_step_d <= step;
`endif
      r_tick <= w_event;
      if (w_event) begin
        r_tick_count <= r_tick_count + 16'd1;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_phase <= 1'b0;
          if (!stop && !pause && start) begin
            r_state      <= S_RUN;
            r_running    <= 1'b1;
            r_tick_count <= 16'd0;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
          end else begin
            r_phase <= w_phase_hi;
            r_cnt   <= w_wrap ? '0 : (r_cnt + CNT_W'(1));
            if (pause) begin
              r_state   <= S_PAUSE;
              r_running <= 1'b0;
            end
          end
        end
        S_PAUSE: begin
          if (stop) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
          end else begin
            // A level change or a single step restarts the frozen period.
            if (w_apply || w_step_evt) begin
              r_cnt <= '0;
            end
            if (start && !pause) begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_cnt     <= '0;
          r_phase   <= 1'b0;
        end
      endcase

      // A manual change always beats a ramp step landing on the same boundary.
      if (w_apply) begin
        r_level    <= r_pend_lvl;
        r_pending  <= 1'b0;
        r_ready    <= 1'b1;
        r_ramp_cnt <= '0;
      end else if (w_event && ramp_en) begin
        if (w_ramp_last) begin
          r_ramp_cnt <= '0;
          if (r_level < 2'd2) begin
            r_level <= r_level + 2'd1;
          end
        end else begin
          r_ramp_cnt <= r_ramp_cnt + RAMP_W'(1);
        end
      end

      // Only accepted while nothing is pending, so never collides with w_apply.
      if (w_xfer) begin
        r_pend_lvl <= w_req_lvl;
        r_pending  <= 1'b1;
        r_ready    <= 1'b0;
      end
    end
  end

  assign tick          = r_tick;
  assign phase_out     = r_phase;
  assign level         = r_level;
  assign running       = r_running;
  assign lvl_req_ready = r_ready;
  assign tick_count    = r_tick_count;

endmodule
